// File: rtl/rom_access_seq.sv
// SRAM0 access sequencer: runs timed read/write cycles for the SNES (one-deep
// pending slot) and lower-priority reads for the SPC7110 DCU.
module rom_access_seq #(
    parameter int ROM_CYCLES = 5,
    parameter int WR_CYCLES  = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNES_RD_START,
    input  logic        SNES_WR_START,
    input  logic [7:0]  SNES_WR_DATA,
    input  logic [23:0] ROM_ADDR,
    input  logic        ROM_HIT,
    input  logic        IS_WRITABLE,
    input  logic        DCU_REQ,
    input  logic [23:0] DCU_ADDR,
    output logic        DCU_ACK,
    output logic [7:0]  DCU_DATA,
    output logic [7:0]  SNES_RD_DATA,
    output logic        SNES_RD_VALID,
    output logic [23:0] MEM_ADDR,
    output logic        MEM_CE_N,
    output logic        MEM_OE_N,
    output logic        MEM_WE_N,
    output logic [7:0]  MEM_DATA_OUT,
    output logic        MEM_DATA_OE,
    input  logic [7:0]  MEM_DATA_IN,
    output logic        BUSY,
    output logic        OVERRUN
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {IDLE, SNES_RD, SNES_WR, DCU_RD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_vld_q, pend_vld_d;
    logic               pend_wr_q, pend_wr_d;
    logic [23:0]        pend_addr_q, pend_addr_d;
    logic [7:0]         pend_data_q, pend_data_d;
    logic [23:0]        mem_addr_q, mem_addr_d;
    logic               ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [7:0]         dout_q, dout_d;
    logic               doe_q, doe_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [7:0]         dcu_data_q, dcu_data_d;
    logic               dcu_ack_q, dcu_ack_d;
    logic               overrun_q, overrun_d;
    logic               rd_cap, wr_cap;

    always_comb begin
        rd_cap      = SNES_RD_START & ROM_HIT;
        wr_cap      = SNES_WR_START & ROM_HIT & IS_WRITABLE;
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_wr_d   = pend_wr_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        mem_addr_d  = mem_addr_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        dout_d      = dout_q;
        doe_d       = doe_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        dcu_data_d  = dcu_data_q;
        dcu_ack_d   = 1'b0;
        overrun_d   = overrun_q;

        // A new capture always lands in the slot; the slot's next value then
        // doubles as "the SNES request visible at this edge" for launch.
        if (rd_cap | wr_cap) begin
            pend_vld_d  = 1'b1;
            pend_wr_d   = ~rd_cap;
            pend_addr_d = ROM_ADDR;
            pend_data_d = SNES_WR_DATA;
            if (pend_vld_q | (rd_cap & wr_cap))
                overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_vld_d) begin
                    pend_vld_d = 1'b0;
                    mem_addr_d = pend_addr_d;
                    ce_n_d     = 1'b0;
                    if (pend_wr_d) begin
                        we_n_d  = 1'b0;
                        doe_d   = 1'b1;
                        dout_d  = pend_data_d;
                        cnt_d   = CNT_W'(WR_CYCLES - 1);
                        state_d = SNES_WR;
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_W'(ROM_CYCLES - 1);
                        state_d = SNES_RD;
                    end
                end else if (DCU_REQ) begin
                    mem_addr_d = DCU_ADDR;
                    ce_n_d     = 1'b0;
                    oe_n_d     = 1'b0;
                    cnt_d      = CNT_W'(ROM_CYCLES - 1);
                    state_d    = DCU_RD;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (state_q == SNES_RD) begin
                        rd_data_d  = MEM_DATA_IN;
                        rd_valid_d = 1'b1;
                    end
                    if (state_q == DCU_RD) begin
                        dcu_data_d = MEM_DATA_IN;
                        dcu_ack_d  = 1'b1;
                    end
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    doe_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            mem_addr_q  <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            dcu_data_q  <= '0;
            dcu_ack_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            mem_addr_q  <= mem_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            dcu_data_q  <= dcu_data_d;
            dcu_ack_q   <= dcu_ack_d;
            overrun_q   <= overrun_d;
        end
    end

    assign MEM_ADDR      = mem_addr_q;
    assign MEM_CE_N      = ce_n_q;
    assign MEM_OE_N      = oe_n_q;
    assign MEM_WE_N      = we_n_q;
    assign MEM_DATA_OUT  = dout_q;
    assign MEM_DATA_OE   = doe_q;
    assign SNES_RD_DATA  = rd_data_q;
    assign SNES_RD_VALID = rd_valid_q;
    assign DCU_DATA      = dcu_data_q;
    assign DCU_ACK       = dcu_ack_q;
    assign BUSY          = (state_q != IDLE);
    assign OVERRUN       = overrun_q;

endmodule
